fpadd_pipe16: RTL and testbench

- Two-stage pipelined IEEE-754 binary16 (half-precision) adder.
- Each clock it accepts operands `a` and `b` and, one cycle after capture, presents their sum on `out`.
- It also reports an `overflow`/special-value flag and an effective-subtraction flag.
- It is the floating-point add datapath block; it is fed directly by operand registers and has no handshake.

---
 rtl/fpadd_pipe16.sv | 118 +++++++++++
 tb/tb_fpadd_pipe16.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/fpadd_pipe16.sv
// Two-stage pipelined binary16 adder: stage 1 unpacks, orders and aligns the operands,
// stage 2 adds or subtracts, normalizes, truncates and flags specials/overflow.
module fpadd_pipe16 (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] out,
    output logic        overflow,
    output logic        sub
);

    logic [14:0] mag_a, mag_b, mag_l, mag_s;
    logic        a_big;
    logic [10:0] sig_s_raw;
    logic [4:0]  shamt;

    logic        sign_d, eff_sub_d, special_d;
    logic [4:0]  exp_l_d;
    logic [10:0] sig_l_d, sig_s_d;

    logic        sign_q, eff_sub_q, special_q;
    logic [4:0]  exp_l_q;
    logic [10:0] sig_l_q, sig_s_q;

    logic [11:0] sum;
    logic [3:0]  lz;
    logic        found;
    logic [5:0]  exp_inc;
    logic [9:0]  frac;
    logic [15:0] out_d, out_q;
    logic        ovf_d, ovf_q, sub_q;

    always_comb begin
        // Exponent-zero operands are flushed to zero before ordering.
        mag_a     = (a[14:10] == 5'd0) ? 15'd0 : a[14:0];
        mag_b     = (b[14:10] == 5'd0) ? 15'd0 : b[14:0];
        a_big     = (mag_a >= mag_b);
        mag_l     = a_big ? mag_a : mag_b;
        mag_s     = a_big ? mag_b : mag_a;
        sign_d    = a_big ? a[15] : b[15];
        eff_sub_d = a[15] ^ b[15];
        special_d = (a[14:10] == 5'h1F) || (b[14:10] == 5'h1F);
        exp_l_d   = mag_l[14:10];
        sig_l_d   = (mag_l[14:10] == 5'd0) ? 11'd0 : {1'b1, mag_l[9:0]};
        sig_s_raw = (mag_s[14:10] == 5'd0) ? 11'd0 : {1'b1, mag_s[9:0]};
        shamt     = mag_l[14:10] - mag_s[14:10];
        // Bits shifted below the larger operand's LSB are truncated here; large gaps yield zero.
        sig_s_d   = sig_s_raw >> shamt;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sign_q    <= 1'b0;
            eff_sub_q <= 1'b0;
            special_q <= 1'b0;
            exp_l_q   <= 5'd0;
            sig_l_q   <= 11'd0;
            sig_s_q   <= 11'd0;
        end else begin
            sign_q    <= sign_d;
            eff_sub_q <= eff_sub_d;
            special_q <= special_d;
            exp_l_q   <= exp_l_d;
            sig_l_q   <= sig_l_d;
            sig_s_q   <= sig_s_d;
        end
    end

    always_comb begin
        sum = eff_sub_q ? ({1'b0, sig_l_q} - {1'b0, sig_s_q})
                        : ({1'b0, sig_l_q} + {1'b0, sig_s_q});
        lz    = 4'd0;
        found = 1'b0;
        for (int i = 10; i >= 0; i--) begin
            if (!found && sum[i]) begin
                lz    = 4'(10 - i);
                found = 1'b1;
            end
        end
        exp_inc = {1'b0, exp_l_q} + 6'd1;
        frac    = 10'd0;
        out_d   = 16'h0000;
        ovf_d   = 1'b0;
        if (special_q) begin
            out_d = 16'h7FFF;
            ovf_d = 1'b1;
        end else if (sum[11]) begin
            frac = sum[10:1];
            if (exp_inc >= 6'd31) begin
                out_d = {sign_q, 5'h1F, 10'h000};
                ovf_d = 1'b1;
            end else begin
                out_d = {sign_q, exp_inc[4:0], frac};
            end
        end else if ((sum != 12'd0) && (exp_l_q > {1'b0, lz})) begin
            frac  = 10'(sum[10:0] << lz);
            out_d = {sign_q, exp_l_q - {1'b0, lz}, frac};
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            out_q <= 16'h0000;
            ovf_q <= 1'b0;
            sub_q <= 1'b0;
        end else begin
            out_q <= out_d;
            ovf_q <= ovf_d;
            sub_q <= eff_sub_q;
        end
    end

    assign out      = out_q;
    assign overflow = ovf_q;
    assign sub      = sub_q;

endmodule

// File: tb/tb_fpadd_pipe16.sv
// Self-checking bench for fpadd_pipe16: directed vectors plus random operands
// against an integer-arithmetic reference of the truncating binary16 add.
module tb_fpadd_pipe16;

    logic        CLK;
    logic        RST;
    logic [15:0] a, b;
    logic [15:0] out;
    logic        overflow, sub;

    int n_vec;
    int n_err;

    logic [17:0] exp_fifo[$];
    bit          vld_fifo[$];
    string       tag_fifo[$];

    logic [15:0] x, y;

    fpadd_pipe16 dut (
        .CLK      (CLK),
        .RST      (RST),
        .a        (a),
        .b        (b),
        .out      (out),
        .overflow (overflow),
        .sub      (sub)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [17:0] obs, input logic [17:0] want);
        n_vec++;
        if (obs !== want) begin
            n_err++;
            $display("FAIL %s: got ovf=%b sub=%b out=%h, expected ovf=%b sub=%b out=%h",
                     tag, obs[17], obs[16], obs[15:0], want[17], want[16], want[15:0]);
        end
    endtask

    // Result packed as {overflow, sub, out}.
    function automatic logic [17:0] ref_add(input logic [15:0] p, input logic [15:0] q);
        longint mp, mq, ml, ms, r;
        int     el, e;
        logic   sl, sb;
        sb = p[15] ^ q[15];
        if (p[14:10] == 5'h1F || q[14:10] == 5'h1F)
            return {1'b1, sb, 16'h7FFF};
        mp = (p[14:10] == 5'd0) ? 64'sd0 : (longint'(1024 + int'(p[9:0])) << p[14:10]);
        mq = (q[14:10] == 5'd0) ? 64'sd0 : (longint'(1024 + int'(q[9:0])) << q[14:10]);
        if (mp >= mq) begin
            ml = mp; ms = mq; el = int'(p[14:10]); sl = p[15];
        end else begin
            ml = mq; ms = mp; el = int'(q[14:10]); sl = q[15];
        end
        if (ml == 0)
            return {1'b0, sb, 16'h0000};
        // Work in units of the larger operand's LSB; the smaller value is truncated to that grid.
        r = ml >> el;
        r = sb ? (r - (ms >> el)) : (r + (ms >> el));
        if (r == 0)
            return {1'b0, sb, 16'h0000};
        e = el;
        while (r >= 2048) begin r = r >> 1; e++; end
        while (r < 1024)  begin r = r << 1; e--; end
        if (e <= 0)
            return {1'b0, sb, 16'h0000};
        if (e >= 31)
            return {1'b1, sb, sl, 5'h1F, 10'h000};
        return {1'b0, sb, sl, 5'(e), 10'(r)};
    endfunction

    task automatic step(input logic [15:0] p, input logic [15:0] q,
                        input logic [17:0] want, input bit v, input string tag);
        logic [17:0] ee;
        bit          vv;
        string       tt;
        @(negedge CLK);
        if (vld_fifo.size() == 2) begin
            ee = exp_fifo.pop_front();
            vv = vld_fifo.pop_front();
            tt = tag_fifo.pop_front();
            if (vv) chk(tt, {overflow, sub, out}, ee);
        end
        a = p;
        b = q;
        exp_fifo.push_back(want);
        vld_fifo.push_back(v);
        tag_fifo.push_back(tag);
    endtask

    task automatic dir(input logic [15:0] p, input logic [15:0] q,
                       input logic [15:0] o, input logic ov, input logic sb);
        step(p, q, {ov, sb, o}, 1'b1, $sformatf("dir %h+%h", p, q));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        RST = 1'b0;
        a = 16'h0000;
        b = 16'h0000;

        repeat (2) @(posedge CLK);
        #1 chk("reset", {overflow, sub, out}, 18'h0);

        // Latency: result appears after the second edge following capture.
        @(negedge CLK);
        RST = 1'b1;
        a = 16'h5285;
        b = 16'h9f1a;
        @(posedge CLK);
        #1 chk("lat_edge1", {overflow, sub, out}, 18'h0);
        a = 16'h3c00;
        b = 16'h3c00;
        @(posedge CLK);
        #1 chk("lat_edge2", {overflow, sub, out}, {1'b0, 1'b1, 16'h5285});
        @(posedge CLK);
        #1 chk("lat_edge3", {overflow, sub, out}, {1'b0, 1'b0, 16'h4000});

        dir(16'h37df, 16'h53cf, 16'h53de, 1'b0, 1'b0);
        dir(16'h5494, 16'hc858, 16'h5409, 1'b0, 1'b1);
        dir(16'h9b5c, 16'h1a86, 16'h8eb0, 1'b0, 1'b1);
        dir(16'hc220, 16'h4bc9, 16'h4a41, 1'b0, 1'b1);
        dir(16'hfc64, 16'h6cd5, 16'h7fff, 1'b1, 1'b1);
        dir(16'h148a, 16'h7c43, 16'h7fff, 1'b1, 1'b0);
        dir(16'h3c00, 16'hbc00, 16'h0000, 1'b0, 1'b1);
        dir(16'hf02f, 16'h40cd, 16'hf02f, 1'b0, 1'b1);
        dir(16'h16d6, 16'h1be0, 16'h1da5, 1'b0, 1'b0);
        dir(16'h0401, 16'h8400, 16'h0000, 1'b0, 1'b1);
        dir(16'h3c00, 16'h0200, 16'h3c00, 1'b0, 1'b0);
        dir(16'h0001, 16'h0002, 16'h0000, 1'b0, 1'b0);
        dir(16'h7800, 16'h0c00, 16'h7800, 1'b0, 1'b0);
        dir(16'h5285, 16'h9f1a, 16'h5285, 1'b0, 1'b1);
        dir(16'h7bff, 16'h7bff, 16'h7c00, 1'b1, 1'b0);

        // Asynchronous reset mid-stream: outputs clear without a clock edge.
        @(negedge CLK);
        #2 RST = 1'b0;
        #1 chk("async_rst", {overflow, sub, out}, 18'h0);
        exp_fifo.delete();
        vld_fifo.delete();
        tag_fifo.delete();
        @(posedge CLK);
        #2 RST = 1'b1;
        dir(16'h3c00, 16'h3c00, 16'h4000, 1'b0, 1'b0);
        @(posedge CLK);
        #1 chk("rst_rel_edge1", {overflow, sub, out}, 18'h0);
        dir(16'hc220, 16'h4bc9, 16'h4a41, 1'b0, 1'b1);

        for (int i = 0; i < 400; i++) begin
            x = 16'($urandom);
            if ($urandom_range(0, 1) == 1)
                y = 16'($urandom);
            else
                y = x ^ {1'($urandom_range(0, 1)), 3'b000, 12'($urandom_range(0, 4095))};
            step(x, y, ref_add(x, y), 1'b1, $sformatf("rand %h+%h", x, y));
        end

        repeat (2) step(16'h0000, 16'h0000, 18'h0, 1'b0, "drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
